// File: rtl/uart_pkg.sv
// Shared UART framing definitions: state encoding and parity modes,
// common to the receive framer and the future transmit framer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        DONE      = 3'd5,
        WAIT_IDLE = 3'd6
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Nonzero when the received parity bit disagrees with the configured mode.
    function automatic logic parity_mismatch(input logic data_xor,
                                             input logic par_bit,
                                             input logic par_mode);
        return data_xor ^ par_bit ^ par_mode;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side UART bundle: pad line and baud tick in, framed byte and strobes out.
interface uart_rx_frame_if #(parameter int DATA_BITS = 8);
    logic                 rx;
    logic                 rx_clk;
    logic                 rx_clk_en;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        input  rx, rx_clk,
        output rx_clk_en, rx_data, rx_valid, rx_busy, frame_err, parity_err
    );

    modport slave (
        output rx, rx_clk,
        input  rx_clk_en, rx_data, rx_valid, rx_busy, frame_err, parity_err
    );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input.
// Two-cycle latency; the reset value is chosen to match the input's idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, baud-tick gated sampling, parity/stop checks.
// Strobes land one cycle after the final stop-bit tick; rx_data updates only on good frames.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_frame_if.master rx_if
);

    localparam int             CW        = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0]  LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0]  LAST_STOP = CW'(STOP_BITS - 1);
    localparam logic           PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic rx_s;
    logic rx_prev_q;
    logic fall;

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_flag_q, par_flag_d;
    logic                 frm_flag_q, frm_flag_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 frm_next;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_if.rx),
        .q_o (rx_s)
    );

    assign fall = rx_prev_q & ~rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_flag_q <= 1'b0;
            frm_flag_q <= 1'b0;
            rx_data_q  <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            rx_prev_q  <= rx_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_flag_q <= par_flag_d;
            frm_flag_q <= frm_flag_d;
            rx_data_q  <= rx_data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_flag_d = par_flag_q;
        frm_flag_d = frm_flag_q;
        rx_data_d  = rx_data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
        frm_next   = frm_flag_q | ~rx_s;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = START;
                    par_flag_d = 1'b0;
                    frm_flag_d = 1'b0;
                end
            end
            START: begin
                if (rx_if.rx_clk) begin
                    state_d   = rx_s ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                // Right-shift LSB-first: after DATA_BITS samples bit 0 sits at index 0.
                if (rx_if.rx_clk) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (rx_if.rx_clk) begin
                    par_flag_d = parity_mismatch(^shift_q, rx_s, PAR_MODE);
                    state_d    = STOP;
                    bit_cnt_d  = '0;
                end
            end
            STOP: begin
                if (rx_if.rx_clk) begin
                    frm_flag_d = frm_next;
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = DONE;
                        if (frm_next) begin
                            ferr_d = 1'b1;
                        end else begin
                            valid_d   = 1'b1;
                            rx_data_d = shift_q;
                            perr_d    = par_flag_q;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                // A held-low line parks here so a break yields one frame_err only.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_if.rx_busy    = (state_q != IDLE) && (state_q != WAIT_IDLE);
    assign rx_if.rx_clk_en  = rx_if.rx_busy;
    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.parity_err = perr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed scoreboard bench for uart_rx_frame: an 8N1 instance and an 8E1 instance,
// each fed by a divide-by-10 baud generator model ticking five cycles into the bit.
module tb_uart_rx_frame;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_frame_if #(.DATA_BITS(8)) a_if ();
    uart_rx_frame_if #(.DATA_BITS(8)) p_if ();

    uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .rx_if (a_if.master)
    );

    uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
        .clk   (clk),
        .rst   (rst),
        .rx_if (p_if.master)
    );

    // Baud generator model: counter held at 0 while disabled, tick at count 4.
    int cnt_a, cnt_p;
    always @(posedge clk or posedge rst) begin
        if (rst) cnt_a <= 0;
        else if (!a_if.rx_clk_en) cnt_a <= 0;
        else cnt_a <= (cnt_a == 9) ? 0 : cnt_a + 1;
    end
    always @(posedge clk or posedge rst) begin
        if (rst) cnt_p <= 0;
        else if (!p_if.rx_clk_en) cnt_p <= 0;
        else cnt_p <= (cnt_p == 9) ? 0 : cnt_p + 1;
    end
    assign a_if.rx_clk = a_if.rx_clk_en && (cnt_a == 4);
    assign p_if.rx_clk = p_if.rx_clk_en && (cnt_p == 4);

    typedef struct {
        logic       valid;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_p[$];
    exp_t e_a, e_p;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    int valid_a = 0, ferr_a = 0, valid_p = 0;
    int en_rise_a = 0, busy_cnt_a = 0;
    logic en_prev_a = 1'b0;
    logic [7:0] last_a = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_if.rx_clk_en && !en_prev_a) en_rise_a++;
            if (a_if.rx_busy) busy_cnt_a++;
            if (a_if.rx_valid) valid_a++;
            if (a_if.frame_err) ferr_a++;
            if (a_if.rx_valid || a_if.frame_err || a_if.parity_err) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_strobe",
                          {29'd0, a_if.rx_valid, a_if.frame_err, a_if.parity_err}, 32'd0);
                end else begin
                    e_a = q_a.pop_front();
                    check("a_rx_valid", a_if.rx_valid, e_a.valid);
                    check("a_frame_err", a_if.frame_err, e_a.ferr);
                    check("a_parity_err", a_if.parity_err, e_a.perr);
                    check("a_rx_data", a_if.rx_data, e_a.data);
                end
            end
        end
        en_prev_a = a_if.rx_clk_en;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (p_if.rx_valid) valid_p++;
            if (p_if.rx_valid || p_if.frame_err || p_if.parity_err) begin
                if (q_p.size() == 0) begin
                    check("p_unexpected_strobe",
                          {29'd0, p_if.rx_valid, p_if.frame_err, p_if.parity_err}, 32'd0);
                end else begin
                    e_p = q_p.pop_front();
                    check("p_rx_valid", p_if.rx_valid, e_p.valid);
                    check("p_frame_err", p_if.frame_err, e_p.ferr);
                    check("p_parity_err", p_if.parity_err, e_p.perr);
                    check("p_rx_data", p_if.rx_data, e_p.data);
                end
            end
        end
    end

    task automatic bit_a(input logic v);
        a_if.rx = v;
        repeat (10) @(negedge clk);
    endtask

    task automatic bit_p(input logic v);
        p_if.rx = v;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] b, input logic stop);
        bit_a(1'b0);
        for (int i = 0; i < 8; i++) bit_a(b[i]);
        bit_a(stop);
    endtask

    task automatic send_p(input logic [7:0] b, input logic par, input logic stop);
        bit_p(1'b0);
        for (int i = 0; i < 8; i++) bit_p(b[i]);
        bit_p(par);
        bit_p(stop);
    endtask

    task automatic push_good_a(input logic [7:0] b);
        q_a.push_back('{valid: 1'b1, ferr: 1'b0, perr: 1'b0, data: b});
        last_a = b;
    endtask

    int er;

    initial begin
        a_if.rx = 1'b1;
        p_if.rx = 1'b1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_valid", a_if.rx_valid, 1'b0);
        check("reset_frame_err", a_if.frame_err, 1'b0);
        check("reset_parity_err", a_if.parity_err, 1'b0);
        check("reset_rx_busy", a_if.rx_busy, 1'b0);
        check("reset_rx_clk_en", a_if.rx_clk_en, 1'b0);
        check("reset_rx_data", a_if.rx_data, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Good 8N1 frame
        busy_cnt_a = 0;
        push_good_a(8'hA5);
        send_a(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        check("busy_span_about_10_bits", (busy_cnt_a >= 90 && busy_cnt_a <= 100), 1'b1);

        // Bad stop bit, line then held low (break)
        q_a.push_back('{valid: 1'b0, ferr: 1'b1, perr: 1'b0, data: last_a});
        send_a(8'h3C, 1'b0);
        repeat (30) @(negedge clk);
        check("break_busy_low", a_if.rx_busy, 1'b0);
        check("break_clk_en_low", a_if.rx_clk_en, 1'b0);
        er = en_rise_a;
        a_if.rx = 1'b1;
        repeat (20) @(negedge clk);
        check("break_no_retrigger", en_rise_a, er);
        check("break_data_held", a_if.rx_data, 8'hA5);
        check("break_single_frame_err", ferr_a, 1);

        // Start glitch of 3 cycles
        er = en_rise_a;
        a_if.rx = 1'b0;
        repeat (3) @(negedge clk);
        a_if.rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_clk_en_pulsed", en_rise_a, er + 1);
        check("glitch_clk_en_dropped", a_if.rx_clk_en, 1'b0);
        check("glitch_busy_low", a_if.rx_busy, 1'b0);
        push_good_a(8'h5A);
        send_a(8'h5A, 1'b1);
        repeat (20) @(negedge clk);

        // Even parity on the second instance
        q_p.push_back('{valid: 1'b1, ferr: 1'b0, perr: 1'b1, data: 8'h01});
        send_p(8'h01, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        q_p.push_back('{valid: 1'b1, ferr: 1'b0, perr: 1'b0, data: 8'h01});
        send_p(8'h01, 1'b1, 1'b1);
        repeat (20) @(negedge clk);

        // Reset in the middle of data bit 4 of 0xFF
        bit_a(1'b0);
        for (int i = 0; i < 4; i++) bit_a(1'b1);
        repeat (5) @(negedge clk);
        check("midframe_busy_before_rst", a_if.rx_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_rx_valid", a_if.rx_valid, 1'b0);
        check("midrst_frame_err", a_if.frame_err, 1'b0);
        check("midrst_parity_err", a_if.parity_err, 1'b0);
        check("midrst_rx_busy", a_if.rx_busy, 1'b0);
        check("midrst_rx_clk_en", a_if.rx_clk_en, 1'b0);
        check("midrst_rx_data", a_if.rx_data, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_a = 8'h00;
        repeat (60) @(negedge clk);
        check("post_rst_idle_busy", a_if.rx_busy, 1'b0);
        push_good_a(8'h81);
        send_a(8'h81, 1'b1);
        repeat (20) @(negedge clk);

        // Back-to-back frames with no idle gap
        er = en_rise_a;
        push_good_a(8'h00);
        push_good_a(8'hFF);
        send_a(8'h00, 1'b1);
        send_a(8'hFF, 1'b1);
        repeat (20) @(negedge clk);
        check("b2b_clk_en_reasserted", en_rise_a - er, 2);
        check("final_rx_data", a_if.rx_data, 8'hFF);

        check("a_scoreboard_drained", q_a.size(), 0);
        check("p_scoreboard_drained", q_p.size(), 0);
        check("a_valid_pulses", valid_a, 5);
        check("a_frame_err_pulses", ferr_a, 1);
        check("p_valid_pulses", valid_p, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
